// File: rtl/pong_pkg.sv
// rtl/pong_pkg.sv - shared state encoding, key codes and score packing helper for the pong controller
package pong_pkg;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_SERVE     = 3'd1;
    localparam logic [2:0] ST_PLAY      = 3'd2;
    localparam logic [2:0] ST_POINT     = 3'd3;
    localparam logic [2:0] ST_GAME_OVER = 3'd4;
    localparam logic [2:0] ST_PAUSED    = 3'd5;

    localparam logic [7:0] KEY_START_DEF = 8'd32;
    localparam logic [7:0] KEY_RESET_DEF = 8'd114;
    localparam logic [7:0] KEY_PAUSE_DEF = 8'd112;

    // Low bit of player k's field inside the packed score bus.
    function automatic int score_lsb(input int k, input int w);
        return k * w;
    endfunction

endpackage

// File: rtl/pong_tick_timer.sv
// rtl/pong_tick_timer.sv - tick-gated counter with sync clear, programmable length and done strobe
module pong_tick_timer #(
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             tick,
    input  logic [CNT_W-1:0] len,
    output logic             done
);

    logic [CNT_W-1:0] cnt;

    // Done fires on the tick that completes the programmed length; the count rearms itself.
    assign done = tick && !clear && (cnt == len - CNT_W'(1));

    always_ff @(posedge clk) begin
        if (rst || clear || done) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/pong_game_ctrl.sv
// rtl/pong_game_ctrl.sv - pong match flow controller; define PONG_PAUSE_EN for the pause state
module pong_game_ctrl
    import pong_pkg::*;
#(
    parameter int         NUM_PLAYERS = 2,
    parameter int         SCORE_W     = 4,
    parameter int         WIN_SCORE   = 11,
    parameter int         SERVE_TICKS = 60,
    parameter int         POINT_TICKS = 30,
    parameter logic [7:0] KEY_START   = KEY_START_DEF,
    parameter logic [7:0] KEY_RESET   = KEY_RESET_DEF,
    parameter logic [7:0] KEY_PAUSE   = KEY_PAUSE_DEF
) (
    input  logic                           i_CLK,
    input  logic                           i_RST,
    input  logic                           i_tick,
    input  logic                           i_key_valid,
    input  logic [7:0]                     i_key_byte,
    input  logic [NUM_PLAYERS-1:0]         i_scored,
    output logic [2:0]                     o_state,
    output logic                           o_ball_run,
    output logic                           o_ball_reset,
    output logic [1:0]                     o_serve_to,
    output logic [NUM_PLAYERS*SCORE_W-1:0] o_scores,
    output logic [1:0]                     o_winner,
    output logic                           o_winner_valid
);

    localparam int MAX_T = (SERVE_TICKS > POINT_TICKS) ? SERVE_TICKS : POINT_TICKS;
    localparam int CNT_W = $clog2(MAX_T + 1);

    if (NUM_PLAYERS < 2 || NUM_PLAYERS > 4) begin : g_bad_players
        $error("pong_game_ctrl: NUM_PLAYERS must be 2..4");
    end
    if ((1 << SCORE_W) <= WIN_SCORE) begin : g_bad_score_w
        $error("pong_game_ctrl: SCORE_W too narrow for WIN_SCORE");
    end
    if (SERVE_TICKS < 1 || POINT_TICKS < 1) begin : g_bad_ticks
        $error("pong_game_ctrl: tick lengths must be at least 1");
    end
    if (KEY_PAUSE == KEY_START || KEY_PAUSE == KEY_RESET || KEY_START == KEY_RESET) begin : g_bad_keys
        $error("pong_game_ctrl: key codes must be distinct");
    end

    logic [2:0]             state_q, state_d;
    logic [SCORE_W-1:0]     score_q [NUM_PLAYERS];
    logic                   key_start, key_reset;
    logic                   hit, hit_win;
    logic [1:0]             hit_idx, next_serve;
    logic [NUM_PLAYERS-1:0] credit;
    logic                   timed, tmr_done;
    logic [CNT_W-1:0]       tmr_len;

    assign key_start = i_key_valid && (i_key_byte == KEY_START);
    assign key_reset = i_key_valid && (i_key_byte == KEY_RESET);
`ifdef PONG_PAUSE_EN
    logic key_pause;
    assign key_pause = i_key_valid && (i_key_byte == KEY_PAUSE);
`endif

    assign timed   = (state_q == ST_SERVE) || (state_q == ST_POINT);
    assign tmr_len = (state_q == ST_SERVE) ? CNT_W'(SERVE_TICKS) : CNT_W'(POINT_TICKS);

    pong_tick_timer #(.CNT_W(CNT_W)) u_timer (
        .clk   (i_CLK),
        .rst   (i_RST),
        .clear (key_reset || !timed),
        .tick  (i_tick && timed),
        .len   (tmr_len),
        .done  (tmr_done)
    );

    // Only the lowest-indexed scorer in a cycle is credited.
    always_comb begin
        hit        = 1'b0;
        hit_win    = 1'b0;
        hit_idx    = 2'd0;
        next_serve = 2'd0;
        credit     = '0;
        for (int i = NUM_PLAYERS - 1; i >= 0; i--) begin
            if (i_scored[i]) begin
                hit        = 1'b1;
                hit_idx    = 2'(i);
                hit_win    = (score_q[i] == SCORE_W'(WIN_SCORE - 1));
                next_serve = (i == NUM_PLAYERS - 1) ? 2'd0 : 2'(i + 1);
                credit     = '0;
                credit[i]  = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:      if (key_start) state_d = ST_SERVE;
            ST_SERVE:     if (tmr_done) state_d = ST_PLAY;
            ST_PLAY: begin
                if (hit) state_d = hit_win ? ST_GAME_OVER : ST_POINT;
`ifdef PONG_PAUSE_EN
                else if (key_pause) state_d = ST_PAUSED;
`endif
            end
            ST_POINT:     if (tmr_done) state_d = ST_SERVE;
            ST_GAME_OVER: if (key_start) state_d = ST_SERVE;
`ifdef PONG_PAUSE_EN
            ST_PAUSED:    if (key_pause) state_d = ST_PLAY;
`endif
            default:      state_d = ST_IDLE;
        endcase
        if (key_reset) state_d = ST_IDLE;
    end

    always_ff @(posedge i_CLK) begin
        if (i_RST || key_reset) begin
            state_q        <= ST_IDLE;
            o_serve_to     <= 2'd0;
            o_winner       <= 2'd0;
            o_winner_valid <= 1'b0;
            o_ball_run     <= 1'b0;
            o_ball_reset   <= 1'b1;
            for (int i = 0; i < NUM_PLAYERS; i++) score_q[i] <= '0;
        end else begin
            state_q        <= state_d;
            o_ball_run     <= (state_d == ST_PLAY);
            o_ball_reset   <= (state_d == ST_IDLE) || (state_d == ST_SERVE) ||
                              (state_d == ST_GAME_OVER);
            o_winner_valid <= (state_d == ST_GAME_OVER);
            if (key_start && ((state_q == ST_IDLE) || (state_q == ST_GAME_OVER))) begin
                o_serve_to <= 2'd0;
                for (int i = 0; i < NUM_PLAYERS; i++) score_q[i] <= '0;
            end
            if ((state_q == ST_PLAY) && hit) begin
                for (int i = 0; i < NUM_PLAYERS; i++) begin
                    if (credit[i]) score_q[i] <= score_q[i] + SCORE_W'(1);
                end
                if (hit_win) o_winner <= hit_idx;
                else         o_serve_to <= next_serve;
            end
        end
    end

    assign o_state = state_q;

    for (genvar g = 0; g < NUM_PLAYERS; g++) begin : g_scores
        assign o_scores[score_lsb(g, SCORE_W) +: SCORE_W] = score_q[g];
    end

endmodule

// File: tb/tb_pong_game_ctrl.sv
// tb/tb_pong_game_ctrl.sv - directed self-checking bench for pong_game_ctrl with a match-level model
module tb_pong_game_ctrl;

    localparam int N     = 2;
    localparam int SW    = 4;
    localparam int WIN   = 11;
    localparam int SERVE = 60;
    localparam int POINT = 30;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         tick = 1'b0;
    logic         kv = 1'b0;
    logic [7:0]   kb = 8'd0;
    logic [N-1:0] sc = '0;
    logic [2:0]   o_state;
    logic         o_ball_run, o_ball_reset, o_winner_valid;
    logic [1:0]   o_serve_to, o_winner;
    logic [N*SW-1:0] o_scores;

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_en = 0;

    int m_phase;
    int m_cnt;
    int m_serve;
    int m_winner;
    int m_score [N];

    pong_game_ctrl dut (
        .i_CLK          (clk),
        .i_RST          (rst),
        .i_tick         (tick),
        .i_key_valid    (kv),
        .i_key_byte     (kb),
        .i_scored       (sc),
        .o_state        (o_state),
        .o_ball_run     (o_ball_run),
        .o_ball_reset   (o_ball_reset),
        .o_serve_to     (o_serve_to),
        .o_scores       (o_scores),
        .o_winner       (o_winner),
        .o_winner_valid (o_winner_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic clear_match();
        for (int k = 0; k < N; k++) m_score[k] = 0;
        m_cnt   = 0;
        m_serve = 0;
    endtask

    // Match rules: phases 0 idle, 1 serve, 2 play, 3 point, 4 game over, 5 paused.
    task automatic model_step();
        int k;
        if (rst || (kv && kb == 8'd114)) begin
            m_phase  = 0;
            m_winner = 0;
            clear_match();
            return;
        end
        case (m_phase)
            0, 4: if (kv && kb == 8'd32) begin
                m_phase = 1;
                clear_match();
            end
            1, 3: if (tick) begin
                m_cnt = m_cnt + 1;
                if (m_cnt == ((m_phase == 1) ? SERVE : POINT)) begin
                    m_cnt   = 0;
                    m_phase = (m_phase == 1) ? 2 : 1;
                end
            end
            2: if (sc != 0) begin
                k = 0;
                while (!sc[k]) k++;
                m_score[k] = m_score[k] + 1;
                if (m_score[k] == WIN) begin
                    m_phase  = 4;
                    m_winner = k;
                end else begin
                    m_phase = 3;
                    m_serve = (k + 1) % N;
                end
            end
`ifdef PONG_PAUSE_EN
            else if (kv && kb == 8'd112) m_phase = 5;
            5: if (kv && kb == 8'd112) m_phase = 2;
`endif
            default: ;
        endcase
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    always @(negedge clk) begin
        logic [N*SW-1:0] exp_sc;
        if (chk_en) begin
            for (int k = 0; k < N; k++) exp_sc[k*SW +: SW] = SW'(m_score[k]);
            chk("model_state", 32'(o_state), 32'(m_phase));
            chk("model_ball_run", 32'(o_ball_run), 32'(m_phase == 2));
            chk("model_ball_reset", 32'(o_ball_reset), 32'(m_phase == 0 || m_phase == 1 || m_phase == 4));
            chk("model_winner_valid", 32'(o_winner_valid), 32'(m_phase == 4));
            chk("model_winner", 32'(o_winner), 32'(m_winner));
            chk("model_serve_to", 32'(o_serve_to), 32'(m_serve));
            chk("model_scores", 32'(o_scores), 32'(exp_sc));
        end
    end

    task automatic cyc(input logic t, input logic v, input logic [7:0] b, input logic [N-1:0] s);
        tick = t;
        kv   = v;
        kb   = b;
        sc   = s;
        @(negedge clk);
        tick = 1'b0;
        kv   = 1'b0;
        kb   = 8'd0;
        sc   = '0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            cyc(1'b1, 1'b0, 8'd0, '0);
            cyc(1'b0, 1'b0, 8'd0, '0);
        end
    endtask

    initial begin
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk_en = 1;
        chk("reset_state", 32'(o_state), 32'd0);
        chk("reset_ball_reset", 32'(o_ball_reset), 32'd1);
        chk("reset_ball_run", 32'(o_ball_run), 32'd0);
        chk("reset_scores", 32'(o_scores), 32'd0);
        chk("reset_winner_valid", 32'(o_winner_valid), 32'd0);

        cyc(1'b0, 1'b1, 8'd120, '0);
        chk("other_key_ignored", 32'(o_state), 32'd0);
        cyc(1'b0, 1'b0, 8'd32, '0);
        chk("key_without_valid", 32'(o_state), 32'd0);

        cyc(1'b1, 1'b1, 8'd32, '0);
        chk("start_to_serve", 32'(o_state), 32'd1);
        ticks(SERVE - 1);
        chk("serve_not_done", 32'(o_state), 32'd1);
        ticks(1);
        chk("serve_to_play", 32'(o_state), 32'd2);
        chk("play_ball_run", 32'(o_ball_run), 32'd1);

        cyc(1'b0, 1'b0, 8'd0, 2'b01);
        chk("point_state", 32'(o_state), 32'd3);
        chk("point_score0", 32'(o_scores), 32'h01);
        chk("point_serve_to", 32'(o_serve_to), 32'd1);
        ticks(POINT - 1);
        chk("point_not_done", 32'(o_state), 32'd3);
        ticks(1);
        chk("point_to_serve", 32'(o_state), 32'd1);

        ticks(SERVE);
        for (int p = 0; p < WIN - 1; p++) begin
            cyc(1'b0, 1'b0, 8'd0, 2'b10);
            ticks(POINT);
            ticks(SERVE);
        end
        chk("p1_at_ten", 32'(o_scores), 32'hA1);
        chk("p1_serve_wrap", 32'(o_serve_to), 32'd0);
        cyc(1'b0, 1'b0, 8'd0, 2'b10);
        chk("game_over_state", 32'(o_state), 32'd4);
        chk("game_over_winner", 32'(o_winner), 32'd1);
        chk("game_over_valid", 32'(o_winner_valid), 32'd1);
        chk("game_over_scores", 32'(o_scores), 32'hB1);
        cyc(1'b1, 1'b0, 8'd0, 2'b01);
        chk("scores_frozen", 32'(o_scores), 32'hB1);
        cyc(1'b0, 1'b1, 8'd32, '0);
        chk("restart_state", 32'(o_state), 32'd1);
        chk("restart_scores", 32'(o_scores), 32'd0);

        cyc(1'b0, 1'b0, 8'd0, 2'b01);
        chk("scored_in_serve", 32'(o_scores), 32'd0);
        ticks(SERVE);
        cyc(1'b0, 1'b0, 8'd0, 2'b11);
        chk("dual_score_lowest", 32'(o_scores), 32'h01);
        ticks(POINT);
        ticks(SERVE);
        chk("back_in_play", 32'(o_state), 32'd2);
        cyc(1'b0, 1'b1, 8'd114, 2'b01);
        chk("abort_state", 32'(o_state), 32'd0);
        chk("abort_scores", 32'(o_scores), 32'd0);

        cyc(1'b0, 1'b1, 8'd32, '0);
        ticks(10);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_serve_reset", 32'(o_state), 32'd0);
        chk("mid_serve_ball_reset", 32'(o_ball_reset), 32'd1);

        cyc(1'b0, 1'b1, 8'd32, '0);
        ticks(SERVE);
        cyc(1'b0, 1'b1, 8'd112, '0);
`ifdef PONG_PAUSE_EN
        chk("pause_state", 32'(o_state), 32'd5);
        chk("pause_ball_run", 32'(o_ball_run), 32'd0);
        chk("pause_ball_reset", 32'(o_ball_reset), 32'd0);
        cyc(1'b0, 1'b0, 8'd0, 2'b01);
        ticks(5);
        chk("pause_scores", 32'(o_scores), 32'd0);
        chk("pause_hold", 32'(o_state), 32'd5);
        cyc(1'b0, 1'b1, 8'd112, '0);
        chk("unpause_state", 32'(o_state), 32'd2);
`else
        chk("pause_ignored", 32'(o_state), 32'd2);
        chk("pause_ignored_run", 32'(o_ball_run), 32'd1);
`endif

        @(negedge clk);
        chk_en = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
